// File: rtl/fp_pkg.sv
// fp_pkg: shared binary32 field widths, types and classification helper.
package fp_pkg;
  localparam int MAN_W = 23;
  localparam int EXP_W = 8;
  localparam logic [EXP_W-1:0] EXP_MAX = 8'hFF;
  typedef enum logic [1:0] {
    FP_NORM = 2'd0,
    FP_ZERO = 2'd1,
    FP_INF  = 2'd2,
    FP_NAN  = 2'd3
  } fp_class_t;
  typedef struct packed {
    logic             sign;
    logic [EXP_W-1:0] exp;
    logic [MAN_W-1:0] man;
  } fp32_t;
  function automatic fp_class_t fp_classify(input fp32_t v);
    return (v.exp == EXP_MAX) ? ((v.man != '0) ? FP_NAN : FP_INF) :
           (v.exp == '0) ? FP_ZERO : FP_NORM;
  endfunction
endpackage

// File: rtl/fp_sync_fifo.sv
// fp_sync_fifo: power-of-two synchronous FIFO with occupancy count.
module fp_sync_fifo #(
  parameter int DEPTH = 8,
  parameter int W = 32,
  parameter int CW = $clog2(2*DEPTH+1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push_i,
  input  logic          pop_i,
  input  logic [W-1:0]  wdata_i,
  output logic [W-1:0]  rdata_o,
  output logic          full_o,
  output logic          empty_o,
  output logic [CW-1:0] count_o
);
  localparam int AW = $clog2(DEPTH);
  logic [W-1:0] mem_q [DEPTH];
  logic [AW-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
  logic [CW-1:0] count_q, count_d;
  logic wr, rd;
  assign full_o  = count_q == CW'(DEPTH);
  assign empty_o = count_q == '0;
  assign count_o = count_q;
  assign rdata_o = mem_q[rptr_q];
  assign rd = pop_i && !empty_o;
  // a pop frees the slot in the same cycle, so a full FIFO still accepts
  assign wr = push_i && (!full_o || rd);
  always_comb begin
    wptr_d  = wptr_q + AW'(wr);
    rptr_d  = rptr_q + AW'(rd);
    count_d = count_q + CW'(wr) - CW'(rd);
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
    end
  end
  always_ff @(posedge clk) begin
    if (wr) mem_q[wptr_q] <= wdata_i;
  end
endmodule

// File: rtl/fp_div_result_buf.sv
// fp_div_result_buf: packs divider results into binary32, buffers them and
// issues credit so the non-stallable divider never overruns the buffer.
module fp_div_result_buf
  import fp_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int CW = $clog2(2*DEPTH+1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             issue,
  output logic             issue_ok,
  input  logic             dst_valid,
  input  logic [MAN_W-1:0] r_man,
  input  logic [EXP_W-1:0] r_exp,
  input  logic             r_sign,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_data,
  output logic [1:0]       out_class,
  output logic [CW-1:0]    count,
  output logic [CW-1:0]    inflight,
  output logic [2:0]       err
);
  fp32_t wr_word, head;
  logic full, empty, pop, spurious, ret;
  logic [CW-1:0] inflight_q, inflight_d;
  logic [2:0] err_q, err_d;
  assign wr_word   = '{sign: r_sign, exp: r_exp, man: r_man};
  assign out_valid = !empty;
  assign pop       = out_valid && out_ready;
  assign out_data  = head;
  assign out_class = fp_classify(head);
  assign inflight  = inflight_q;
  assign err       = err_q;
  fp_sync_fifo #(.DEPTH(DEPTH), .W(32), .CW(CW)) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (dst_valid),
    .pop_i   (pop),
    .wdata_i (wr_word),
    .rdata_o (head),
    .full_o  (full),
    .empty_o (empty),
    .count_o (count)
  );
  // credit uses registered state only, never same-cycle issue/return
  assign issue_ok = ({1'b0, count} + {1'b0, inflight_q}) < (CW+1)'(DEPTH);
  always_comb begin
    spurious   = dst_valid && (inflight_q == '0);
    ret        = dst_valid && !spurious;
    inflight_d = (issue && !ret) ? ((&inflight_q) ? inflight_q : inflight_q + 1'b1) :
                 (!issue && ret) ? inflight_q - 1'b1 : inflight_q;
    err_d      = err_q | {issue && !issue_ok, spurious, dst_valid && full && !pop};
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      inflight_q <= '0;
      err_q      <= '0;
    end else begin
      inflight_q <= inflight_d;
      err_q      <= err_d;
    end
  end
endmodule

// File: tb/tb_fp_div_result_buf.sv
// tb_fp_div_result_buf: scoreboard bench for the divider result buffer.
module tb_fp_div_result_buf;
  localparam int DEPTH = 8;
  localparam int CW = $clog2(2*DEPTH+1);
  logic clk = 0, rst = 1, issue = 0, dst_valid = 0, out_ready = 0;
  logic r_sign = 0;
  logic [7:0] r_exp = 0;
  logic [22:0] r_man = 0;
  logic issue_ok, out_valid;
  logic [31:0] out_data;
  logic [1:0] out_class;
  logic [CW-1:0] count, inflight;
  logic [2:0] err;
  int n_tests = 0, n_fail = 0;
  logic [33:0] sb [$];
  fp_div_result_buf #(.DEPTH(DEPTH), .CW(CW)) dut (
    .clk(clk), .rst(rst), .issue(issue), .issue_ok(issue_ok),
    .dst_valid(dst_valid), .r_man(r_man), .r_exp(r_exp), .r_sign(r_sign),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_class(out_class), .count(count), .inflight(inflight), .err(err)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic iss;
    issue = 1;
    tick();
    issue = 0;
  endtask
  task automatic ret(input logic [31:0] w, input logic [1:0] cls, input logic keep);
    dst_valid = 1;
    {r_sign, r_exp, r_man} = w;
    if (keep) sb.push_back({cls, w});
    tick();
    dst_valid = 0;
  endtask
  task automatic do_reset;
    rst = 1; issue = 0; dst_valid = 0; out_ready = 0;
    sb.delete();
    tick();
    rst = 0;
  endtask
  task automatic drain(input string tag);
    out_ready = 1;
    for (int i = 0; i < 40 && count != 0; i++) tick();
    chk({tag, "_count"}, 32'(count), 0);
    chk({tag, "_sb"}, sb.size(), 0);
    out_ready = 0;
  endtask
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      if (sb.size() == 0) chk("sb_underrun", 1, 0);
      else begin
        logic [33:0] e;
        e = sb.pop_front();
        chk("out_data", out_data, e[31:0]);
        chk("out_class", 32'(out_class), 32'(e[33:32]));
      end
    end
  end
  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end
  initial begin
    tick();
    do_reset();
    chk("rst_count", 32'(count), 0);
    chk("rst_inflight", 32'(inflight), 0);
    chk("rst_out_valid", 32'(out_valid), 0);
    chk("rst_issue_ok", 32'(issue_ok), 1);
    chk("rst_err", 32'(err), 0);
    // single transaction
    out_ready = 1;
    iss();
    chk("t1_inflight1", 32'(inflight), 1);
    tick();
    dst_valid = 1;
    {r_sign, r_exp, r_man} = 32'h3F800000;
    sb.push_back({2'd0, 32'h3F800000});
    #1;
    chk("t1_no_bypass", 32'(out_valid), 0);
    tick();
    dst_valid = 0;
    chk("t1_out_valid", 32'(out_valid), 1);
    chk("t1_inflight0", 32'(inflight), 0);
    tick();
    chk("t1_count0", 32'(count), 0);
    chk("t1_sb", sb.size(), 0);
    // fill
    out_ready = 0;
    for (int i = 0; i < DEPTH; i++) begin
      chk("fill_issue_ok", 32'(issue_ok), 1);
      iss();
    end
    chk("fill_no_credit", 32'(issue_ok), 0);
    chk("fill_inflight", 32'(inflight), DEPTH);
    for (int i = 0; i < DEPTH; i++) ret(32'h40000000 + i, 2'd0, 1);
    chk("full_count", 32'(count), DEPTH);
    chk("full_issue_ok", 32'(issue_ok), 0);
    chk("full_err", 32'(err), 0);
    // push and pop while full
    out_ready = 1;
    ret(32'h41000000, 2'd0, 1);
    out_ready = 0;
    chk("pp_count", 32'(count), DEPTH);
    chk("pp_err0", 32'(err[0]), 0);
    ret(32'h42000000, 2'd0, 0);
    chk("drop_err0", 32'(err[0]), 1);
    chk("drop_count", 32'(count), DEPTH);
    drain("fill_drain");
    // class decode
    do_reset();
    out_ready = 1;
    for (int i = 0; i < 4; i++) iss();
    ret(32'h7F800001, 2'd3, 1);
    ret(32'h7F800000, 2'd2, 1);
    ret(32'h00000005, 2'd1, 1);
    ret(32'h40400000, 2'd0, 1);
    drain("cls_drain");
    chk("cls_err", 32'(err), 0);
    // protocol errors
    do_reset();
    ret(32'h3F800000, 2'd0, 1);
    chk("spur_err", 32'(err), 3'b010);
    chk("spur_inflight", 32'(inflight), 0);
    drain("spur_drain");
    do_reset();
    for (int i = 0; i < DEPTH; i++) iss();
    for (int i = 0; i < DEPTH; i++) ret(32'hC0000000 + i, 2'd0, 1);
    iss();
    chk("nocred_err", 32'(err), 3'b100);
    chk("nocred_inflight", 32'(inflight), 1);
    // reset mid-operation
    do_reset();
    for (int i = 0; i < 7; i++) iss();
    for (int i = 0; i < 5; i++) ret(32'h3F000000 + i, 2'd0, 1);
    chk("mid_count", 32'(count), 5);
    chk("mid_inflight", 32'(inflight), 2);
    do_reset();
    chk("mr_count", 32'(count), 0);
    chk("mr_inflight", 32'(inflight), 0);
    chk("mr_out_valid", 32'(out_valid), 0);
    chk("mr_issue_ok", 32'(issue_ok), 1);
    chk("mr_err", 32'(err), 0);
    tick();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
